// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/flush/freeze sequencing and EX operand forwarding
// for the 16-bit pipeline. Sits beside the decode controller and drives STALL.
//
// Output handshake: there is no valid/ready pair here. Every output is
// meaningful on every cycle. Consumers sample on the rising CLK edge. The
// upstream pipeline keeps its inputs stable for as long as HOLD=1.
module hazard_sequencer #(
  parameter int REG_ADDR_W   = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ID_VALID,
  input  logic [REG_ADDR_W-1:0] ID_RS,
  input  logic [REG_ADDR_W-1:0] ID_RT,
  input  logic                  ID_USE_RS,
  input  logic                  ID_USE_RT,
  input  logic [REG_ADDR_W-1:0] EX_RD,
  input  logic                  EX_REGWRITE,
  input  logic                  EX_MEM2REG,
  input  logic [REG_ADDR_W-1:0] MEM_RD,
  input  logic                  MEM_REGWRITE,
  input  logic                  BRANCH_TAKEN,
  input  logic                  MEM_BUSY,
  output logic                  STALL,
  output logic                  PC_EN,
  output logic                  IFID_EN,
  output logic                  FLUSH,
  output logic                  HOLD,
  output logic [1:0]            FWD_A,
  output logic [1:0]            FWD_B,
  output logic [CNT_W-1:0]      STALL_CNT,
  output logic                  dbg_state,
  output logic [3:0]            dbg_fcnt
);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  // First value loaded into the flush counter when a branch is taken in RUN.
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] fcnt, fcnt_nxt;
  logic       lu;

  // A load in EX produces a register that the ID instruction reads.
  assign lu = ID_VALID & EX_REGWRITE & EX_MEM2REG &
              ((ID_USE_RS & (ID_RS == EX_RD)) | (ID_USE_RT & (ID_RT == EX_RD)));

  assign dbg_state = state;
  assign dbg_fcnt  = fcnt;

  // State and flush-counter registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_RUN;
      fcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Next state and pipeline control. MEM_BUSY outranks a taken branch, which outranks load-use.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    STALL     = 1'b0;
    PC_EN     = 1'b1;
    IFID_EN   = 1'b1;
    FLUSH     = 1'b0;
    HOLD      = 1'b0;
    if (!RST_N) begin
      STALL     = 1'b1;
      PC_EN     = 1'b0;
      IFID_EN   = 1'b0;
      FLUSH     = 1'b1;
      state_nxt = S_RUN;
      fcnt_nxt  = 4'd0;
    end else if (MEM_BUSY) begin
      // Freeze everything; events are re-evaluated once memory is ready.
      HOLD    = 1'b1;
      PC_EN   = 1'b0;
      IFID_EN = 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (BRANCH_TAKEN) begin
            FLUSH = 1'b1;
            STALL = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = S_FLUSH;
              fcnt_nxt  = FLUSH_INIT;
            end
          end else if (lu) begin
            // One bubble is enough: the load moves on to MEM next cycle.
            STALL   = 1'b1;
            PC_EN   = 1'b0;
            IFID_EN = 1'b0;
          end
        end
        S_FLUSH: begin
          // Wrong-path instructions are squashed, so branch/lu are ignored.
          FLUSH    = 1'b1;
          STALL    = 1'b1;
          fcnt_nxt = fcnt - 4'd1;
          if (fcnt <= 4'd1) begin
            state_nxt = S_RUN;
            fcnt_nxt  = 4'd0;
          end
        end
        default: begin
          state_nxt = S_RUN;
          fcnt_nxt  = 4'd0;
        end
      endcase
    end
  end

  // Operand forwarding: the EX/MEM result (non-load) wins over the MEM/WB result.
  always_comb begin
    FWD_A = 2'd0;
    FWD_B = 2'd0;
    if (RST_N) begin
      if (EX_REGWRITE && !EX_MEM2REG && (EX_RD == ID_RS))
        FWD_A = 2'd1;
      else if (MEM_REGWRITE && (MEM_RD == ID_RS))
        FWD_A = 2'd2;
      if (EX_REGWRITE && !EX_MEM2REG && (EX_RD == ID_RT))
        FWD_B = 2'd1;
      else if (MEM_REGWRITE && (MEM_RD == ID_RT))
        FWD_B = 2'd2;
    end
  end

  // Saturating count of cycles spent stalled or frozen.
  always_ff @(posedge CLK) begin
    if (!RST_N)
      STALL_CNT <= '0;
    else if ((STALL || HOLD) && (STALL_CNT != {CNT_W{1'b1}}))
      STALL_CNT <= STALL_CNT + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: a main instance (16-bit counter) and a
// 4-bit-counter instance driven by the same inputs to exercise saturation.
module tb_hazard_sequencer;

  localparam int W = 48;

  // Expected control bits, ordered {STALL, PC_EN, IFID_EN, FLUSH, HOLD}.
  localparam logic [4:0] C_RST  = 5'b10010;
  localparam logic [4:0] C_RUN  = 5'b01100;
  localparam logic [4:0] C_FL   = 5'b11110;
  localparam logic [4:0] C_LU   = 5'b10000;
  localparam logic [4:0] C_HOLD = 5'b00001;

  typedef struct packed {
    logic       rst_n;
    logic       id_valid;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [2:0] ex_rd;
    logic       ex_rw;
    logic       ex_m2r;
    logic [2:0] mem_rd;
    logic       mem_rw;
    logic       br;
    logic       busy;
  } in_t;

  logic clk = 1'b0;
  in_t  cur;

  logic        m_stall, m_pc, m_ifid, m_flush, m_hold, m_st;
  logic [1:0]  m_fa, m_fb;
  logic [3:0]  m_fc;
  logic [15:0] m_cnt;
  logic        s_stall, s_pc, s_ifid, s_flush, s_hold, s_st;
  logic [1:0]  s_fa, s_fb;
  logic [3:0]  s_fc;
  logic [3:0]  s_cnt;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks   = 0;
  int           failures = 0;
  int           exp_cnt  = 0;

  // Clock and reset block: 10 ns clock; reset is driven through cur.rst_n.
  always #5 clk = ~clk;

  hazard_sequencer #(.REG_ADDR_W(3), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .CLK(clk), .RST_N(cur.rst_n), .ID_VALID(cur.id_valid),
    .ID_RS(cur.rs), .ID_RT(cur.rt), .ID_USE_RS(cur.use_rs), .ID_USE_RT(cur.use_rt),
    .EX_RD(cur.ex_rd), .EX_REGWRITE(cur.ex_rw), .EX_MEM2REG(cur.ex_m2r),
    .MEM_RD(cur.mem_rd), .MEM_REGWRITE(cur.mem_rw),
    .BRANCH_TAKEN(cur.br), .MEM_BUSY(cur.busy),
    .STALL(m_stall), .PC_EN(m_pc), .IFID_EN(m_ifid), .FLUSH(m_flush), .HOLD(m_hold),
    .FWD_A(m_fa), .FWD_B(m_fb), .STALL_CNT(m_cnt), .dbg_state(m_st), .dbg_fcnt(m_fc)
  );

  hazard_sequencer #(.REG_ADDR_W(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
    .CLK(clk), .RST_N(cur.rst_n), .ID_VALID(cur.id_valid),
    .ID_RS(cur.rs), .ID_RT(cur.rt), .ID_USE_RS(cur.use_rs), .ID_USE_RT(cur.use_rt),
    .EX_RD(cur.ex_rd), .EX_REGWRITE(cur.ex_rw), .EX_MEM2REG(cur.ex_m2r),
    .MEM_RD(cur.mem_rd), .MEM_REGWRITE(cur.mem_rw),
    .BRANCH_TAKEN(cur.br), .MEM_BUSY(cur.busy),
    .STALL(s_stall), .PC_EN(s_pc), .IFID_EN(s_ifid), .FLUSH(s_flush), .HOLD(s_hold),
    .FWD_A(s_fa), .FWD_B(s_fb), .STALL_CNT(s_cnt), .dbg_state(s_st), .dbg_fcnt(s_fc)
  );

  // Driver: apply one cycle of inputs and queue the hand-computed response.
  // The expected counter values accumulate the expected STALL|HOLD bits.
  task automatic vec(input string name, input logic [4:0] ctl,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic st, input logic [3:0] fc);
    int sat;
    sat = (exp_cnt > 15) ? 15 : exp_cnt;
    exp_q.push_back({ctl, fa, fb, st, fc, 16'(exp_cnt),
                     ctl, fa, fb, st, fc, 4'(sat)});
    name_q.push_back(name);
    @(posedge clk);
    #1;
    if (!cur.rst_n) exp_cnt = 0;
    else if (ctl[4] || ctl[0]) exp_cnt = exp_cnt + 1;
  endtask

  task automatic set_idle();
    cur = '0;
    cur.rst_n = 1'b1;
  endtask

  // Scoreboard monitor: outputs are valid every cycle; compare on the falling edge.
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    string        nm;
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {m_stall, m_pc, m_ifid, m_flush, m_hold, m_fa, m_fb, m_st, m_fc, m_cnt,
             s_stall, s_pc, s_ifid, s_flush, s_hold, s_fa, s_fb, s_st, s_fc, s_cnt};
      checks = checks + 1;
      if (act !== exp) begin
        failures = failures + 1;
        $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
    end
  end

  // Directed stimulus.
  initial begin
    cur = '0;
    cur.br = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt = 0;

    // Reset with a branch and a would-be forward pending: outputs forced.
    cur.ex_rw = 1'b1;
    repeat (3) vec("reset", C_RST, 2'd0, 2'd0, 1'b0, 4'd0);
    set_idle();
    vec("run_idle", C_RUN, 2'd0, 2'd0, 1'b0, 4'd0);

    // Load-use on RS: one-cycle stall, then the bubble clears it.
    cur.id_valid = 1'b1; cur.rs = 3'd3; cur.use_rs = 1'b1; cur.rt = 3'd1; cur.use_rt = 1'b1;
    cur.ex_rd = 3'd3; cur.ex_rw = 1'b1; cur.ex_m2r = 1'b1; cur.mem_rd = 3'd5;
    vec("loaduse", C_LU, 2'd0, 2'd0, 1'b0, 4'd0);
    cur.ex_rw = 1'b0; cur.ex_m2r = 1'b0;
    vec("lu_bubble", C_RUN, 2'd0, 2'd0, 1'b0, 4'd0);

    // Taken branch: two flush cycles, load-use in the second is ignored.
    set_idle(); cur.br = 1'b1;
    vec("br_take", C_FL, 2'd0, 2'd0, 1'b0, 4'd0);
    set_idle();
    cur.id_valid = 1'b1; cur.rs = 3'd3; cur.use_rs = 1'b1;
    cur.ex_rd = 3'd3; cur.ex_rw = 1'b1; cur.ex_m2r = 1'b1;
    vec("br_flush_lu_ign", C_FL, 2'd0, 2'd0, 1'b1, 4'd1);
    set_idle();
    vec("br_done", C_RUN, 2'd0, 2'd0, 1'b0, 4'd0);

    // Memory wait in the middle of a flush: fcnt frozen at 1.
    cur.br = 1'b1;
    vec("br2_take", C_FL, 2'd0, 2'd0, 1'b0, 4'd0);
    set_idle(); cur.busy = 1'b1;
    repeat (3) vec("flush_busy", C_HOLD, 2'd0, 2'd0, 1'b1, 4'd1);
    cur.busy = 1'b0;
    vec("flush_resume", C_FL, 2'd0, 2'd0, 1'b1, 4'd1);
    vec("run2", C_RUN, 2'd0, 2'd0, 1'b0, 4'd0);

    // Forwarding priority and patterns.
    cur.id_valid = 1'b1; cur.use_rs = 1'b1; cur.use_rt = 1'b1; cur.rs = 3'd2; cur.rt = 3'd2;
    cur.ex_rd = 3'd2; cur.ex_rw = 1'b1; cur.mem_rd = 3'd2; cur.mem_rw = 1'b1;
    vec("fwd_ex_prio", C_RUN, 2'd1, 2'd1, 1'b0, 4'd0);
    cur.ex_m2r = 1'b1;
    vec("fwd_lu_mem", C_LU, 2'd2, 2'd2, 1'b0, 4'd0);
    cur.ex_rw = 1'b0; cur.ex_m2r = 1'b0;
    vec("fwd_mem", C_RUN, 2'd2, 2'd2, 1'b0, 4'd0);
    cur.rt = 3'd4; cur.ex_rd = 3'd4; cur.ex_rw = 1'b1;
    vec("fwd_mix", C_RUN, 2'd2, 2'd1, 1'b0, 4'd0);
    cur.rt = 3'd2; cur.ex_rd = 3'd7; cur.mem_rw = 1'b0;
    vec("fwd_none", C_RUN, 2'd0, 2'd0, 1'b0, 4'd0);

    // Load-use via RT, and the qualifiers that suppress it.
    set_idle();
    cur.id_valid = 1'b1; cur.use_rt = 1'b1; cur.rs = 3'd6; cur.rt = 3'd6;
    cur.ex_rd = 3'd6; cur.ex_rw = 1'b1; cur.ex_m2r = 1'b1;
    vec("lu_rt", C_LU, 2'd0, 2'd0, 1'b0, 4'd0);
    cur.use_rt = 1'b0;
    vec("lu_no_use", C_RUN, 2'd0, 2'd0, 1'b0, 4'd0);
    cur.use_rt = 1'b1; cur.id_valid = 1'b0;
    vec("lu_invalid", C_RUN, 2'd0, 2'd0, 1'b0, 4'd0);

    // MEM_BUSY outranks a branch in RUN; the branch is taken once memory is ready.
    set_idle(); cur.busy = 1'b1; cur.br = 1'b1;
    vec("busy_over_br", C_HOLD, 2'd0, 2'd0, 1'b0, 4'd0);
    cur.busy = 1'b0;
    vec("br_after_busy", C_FL, 2'd0, 2'd0, 1'b0, 4'd0);
    cur.br = 1'b0;
    vec("br3_flush", C_FL, 2'd0, 2'd0, 1'b1, 4'd1);
    vec("run3", C_RUN, 2'd0, 2'd0, 1'b0, 4'd0);

    // Long freeze: the 4-bit counter saturates at 15, the 16-bit one keeps counting.
    cur.busy = 1'b1;
    repeat (20) vec("sat_busy", C_HOLD, 2'd0, 2'd0, 1'b0, 4'd0);
    cur.busy = 1'b0;
    vec("sat_done", C_RUN, 2'd0, 2'd0, 1'b0, 4'd0);

    // Reset during operation clears both counters.
    cur.rst_n = 1'b0;
    vec("reset2", C_RST, 2'd0, 2'd0, 1'b0, 4'd0);
    set_idle();
    vec("post_reset", C_RUN, 2'd0, 2'd0, 1'b0, 4'd0);

    // Every queued expectation must have been consumed by the monitor.
    @(negedge clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #20000;
    $display("FAIL timeout reached required=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline hazard and stall sequencer for the 16-bit CPU.
- Sits beside the decode-stage controller and drives its STALL input.
- Gates PC and IF/ID register enables, squashes wrong-path instructions after taken branches, freezes the pipe while data memory is busy, and selects EX-stage operand forwarding.
- Keeps a saturating stall-cycle counter for bring-up and performance checks.

Parameters:
- REG_ADDR_W, 3, register-file address width (8 GPRs; no hardwired zero register).
- FLUSH_CYCLES, 2, bubble cycles inserted per taken branch (legal range 1..15).
- CNT_W, 16, width of the stall performance counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  synchronous reset, active-low, sampled on rising CLK.
- ID_VALID  input  1  ID stage holds a real instruction.
- ID_RS  input  REG_ADDR_W  ID source register A.
- ID_RT  input  REG_ADDR_W  ID source register B.
- ID_USE_RS  input  1  ID instruction reads RS.
- ID_USE_RT  input  1  ID instruction reads RT.
- EX_RD  input  REG_ADDR_W  EX destination register.
- EX_REGWRITE  input  1  EX instruction writes the register file.
- EX_MEM2REG  input  1  EX instruction is a load (LW).
- MEM_RD  input  REG_ADDR_W  MEM destination register.
- MEM_REGWRITE  input  1  MEM instruction writes the register file.
- BRANCH_TAKEN  input  1  EX-stage branch or jump resolved taken (JMP/BGT/BLT/BEQ).
- MEM_BUSY  input  1  data memory not ready this cycle.
- STALL  output  1  to controller; forces decode outputs to bubble.
- PC_EN  output  1  PC register load enable.
- IFID_EN  output  1  IF/ID register load enable.
- FLUSH  output  1  clear IF/ID contents to NOP.
- HOLD  output  1  freeze ID/EX, EX/MEM and MEM/WB registers.
- FWD_A  output  2  EX operand A select: 0 regfile, 1 EX/MEM result, 2 MEM/WB result.
- FWD_B  output  2  EX operand B select, same encoding as FWD_A.
- STALL_CNT  output  CNT_W  saturating count of cycles with STALL=1 or HOLD=1.

Behaviour:
- FSM states: RUN, FLUSH. Registered: state, flush counter fcnt (4 bits), STALL_CNT.
- Reset (RST_N=0 at an edge): state goes to RUN, fcnt=0, STALL_CNT=0. While RST_N=0, outputs are forced: STALL=1, PC_EN=0, IFID_EN=0, FLUSH=1, HOLD=0, FWD_A=FWD_B=0.
- Load-use hazard, combinational: lu = ID_VALID & EX_REGWRITE & EX_MEM2REG & ((ID_USE_RS & ID_RS==EX_RD) | (ID_USE_RT & ID_RT==EX_RD)).
- Event priority each cycle: MEM_BUSY, then BRANCH_TAKEN, then lu.
- MEM_BUSY=1 (any state):
  - HOLD=1, PC_EN=0, IFID_EN=0, STALL=0, FLUSH=0.
  - State and fcnt unchanged; BRANCH_TAKEN and lu are ignored.
  - Events are re-evaluated on the first cycle with MEM_BUSY=0; upstream keeps inputs stable while frozen.
- RUN, BRANCH_TAKEN=1:
  - FLUSH=1, STALL=1, PC_EN=1 (target loads), IFID_EN=1.
  - If FLUSH_CYCLES>1: next state FLUSH, fcnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
- RUN, lu=1: STALL=1, PC_EN=0, IFID_EN=0, FLUSH=0. Lasts one cycle, because the bubble leaves EX.
- RUN, no event: STALL=0, PC_EN=1, IFID_EN=1, FLUSH=0, HOLD=0.
- FLUSH state:
  - FLUSH=1, STALL=1, PC_EN=1, IFID_EN=1; fcnt decrements.
  - At fcnt==1 the next state is RUN.
  - BRANCH_TAKEN and lu are ignored, since those instructions are squashed.
- Forwarding, combinational, valid in every state except reset. For operand A:
  - FWD_A=1 if EX_REGWRITE & !EX_MEM2REG & EX_RD==ID_RS.
  - Else FWD_A=2 if MEM_REGWRITE & MEM_RD==ID_RS.
  - Else FWD_A=0.
  - FWD_B is identical using ID_RT. EX/MEM takes priority over MEM/WB.
- STALL_CNT:
  - Increments by 1 on each edge where (STALL|HOLD)=1 and RST_N=1.
  - Saturates at all-ones; no wrap.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles with BRANCH_TAKEN=1 -> STALL=1, PC_EN=0, FLUSH=1; after release, state RUN, STALL_CNT=0, PC_EN=1.
- Load-use: EX LW r3 (EX_MEM2REG=1, EX_RD=3), ID ADD using RS=3 -> exactly 1 cycle STALL=1, PC_EN=0, IFID_EN=0; next cycle (EX bubble) STALL=0, STALL_CNT=1.
- Taken branch: BRANCH_TAKEN pulse 1 cycle, FLUSH_CYCLES=2 -> FLUSH=1 and STALL=1 for exactly 2 cycles, PC_EN=1 both cycles; lu asserted in the 2nd cycle is ignored.
- Memory wait during flush: BRANCH_TAKEN, then MEM_BUSY=1 for 3 cycles -> HOLD=1 for 3 cycles, fcnt frozen at 1, then 1 more FLUSH cycle; STALL_CNT=5.
- Forwarding priority: EX_RD=MEM_RD=2, both REGWRITE, ID_RS=ID_RT=2 -> FWD_A=FWD_B=1; set EX_MEM2REG=1 -> lu stall and FWD_A=2.
- Saturation: CNT_W=4, hold MEM_BUSY for 20 cycles -> STALL_CNT stops at 15.
